stdp_synapse_array: RTL and testbench

Parametrised successor to the single STDP synapse. It serves N_SYN presynaptic channels converging on one postsynaptic LIF neuron, with per-channel pre traces, a shared post trace, pair-based LTP/LTD and per-channel weights. It produces a registered, saturated summed synaptic current for the post neuron's i_syn input, and a weight readout for debug and test outputs.

---
 rtl/stdp_pkg.sv | 36 +++
 rtl/stdp_trace.sv | 34 +++
 rtl/stdp_synapse_array.sv | 130 +++++++++++++
 tb/tb_stdp_synapse_array.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared constants and helpers for the STDP synapse array.
// Constants are the default values for the array's parameters.
package stdp_pkg;

  localparam int DECIMAL_BITS = 4;
  localparam int ONE          = 1 << DECIMAL_BITS;
  localparam int TRACE_MAX    = 64;
  localparam int TRACE_DECAY  = 1;
  localparam int W_INIT       = ONE;
  localparam int W_MIN        = 4;
  localparam int W_MAX        = 64;
  localparam int LTP_STEP     = 8;
  localparam int LTD_STEP     = 4;

  // Adds a signed step to a value, then clamps the result into [lo, hi].
  // The 32-bit working width leaves headroom above any weight width, so a
  // step near the top of the range saturates instead of wrapping.
  function automatic int sat_step(input int value, input int delta,
                                  input int lo, input int hi);
    int result;
    result = value + delta;
    if (result > hi) begin
      result = hi;
    end else if (result < lo) begin
      result = lo;
    end
    return result;
  endfunction

  // Returns the address width needed to select one of n channels.
  // It never returns 0, so a single-channel array still has a 1-bit address.
  function automatic int addr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stdp_trace.sv
// Single decaying spike trace: loads TRACE_MAX on a spike, otherwise
// decrements by TRACE_DECAY each cycle and saturates at zero.
module stdp_trace #(
  parameter int WIDTH       = 8,
  parameter int TRACE_MAX   = 64,
  parameter int TRACE_DECAY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_spike,
  output logic [WIDTH-1:0] o_trace
);

  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(TRACE_MAX);
  localparam logic [WIDTH-1:0] DECAY_W = WIDTH'(TRACE_DECAY);

  logic [WIDTH-1:0] r_trace;

  // Spike reloads the trace; otherwise it decays toward zero without underflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_trace <= '0;
    end else if (i_spike) begin
      r_trace <= MAX_W;
    end else if (r_trace > DECAY_W) begin
      r_trace <= r_trace - DECAY_W;
    end else begin
      r_trace <= '0;
    end
  end

  assign o_trace = r_trace;

endmodule

// File: rtl/stdp_synapse_array.sv
// N_SYN-channel STDP synapse array feeding one postsynaptic neuron.
// Per-channel pre traces, a shared post trace, pair-based LTP/LTD, and a
// registered, saturated summed current for the neuron's input.
// Optional macro STDP_WEIGHT_LOAD_EN adds a direct weight write port.
module stdp_synapse_array
  import stdp_pkg::*;
#(
  parameter int N_SYN        = 4,
  parameter int WIDTH        = 8,
  parameter int DECIMAL_BITS = stdp_pkg::DECIMAL_BITS,
  parameter int TRACE_MAX    = stdp_pkg::TRACE_MAX,
  parameter int TRACE_DECAY  = stdp_pkg::TRACE_DECAY,
  parameter int W_INIT       = 1 << DECIMAL_BITS,
  parameter int W_MIN        = stdp_pkg::W_MIN,
  parameter int W_MAX        = stdp_pkg::W_MAX,
  parameter int LTP_STEP     = stdp_pkg::LTP_STEP,
  parameter int LTD_STEP     = stdp_pkg::LTD_STEP,
  localparam int AW          = addr_width(N_SYN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    learn_en,
  input  logic [N_SYN-1:0]        pre_spike,
  input  logic                    post_spike,
  output logic signed [WIDTH-1:0] i_syn,
  output logic                    i_syn_sat,
`ifdef STDP_WEIGHT_LOAD_EN
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
`endif
  input  logic [AW-1:0]           rd_addr,
  output logic [WIDTH-1:0]        rd_weight
);

  // Sum width holds N_SYN doubled weights without overflow.
  localparam int SW = WIDTH + $clog2(N_SYN) + 1;
  localparam logic [SW-1:0] I_MAX = SW'((2 ** (WIDTH - 1)) - 1);

  logic [WIDTH-1:0] w_pre_trace [N_SYN];
  logic [WIDTH-1:0] w_post_trace;
  logic [WIDTH-1:0] r_weight    [N_SYN];
  logic [WIDTH-1:0] w_weight_nx [N_SYN];
  logic [SW-1:0]    w_sum;

  genvar gk;
  generate
    for (gk = 0; gk < N_SYN; gk++) begin : g_pre_trace
      stdp_trace #(
        .WIDTH      (WIDTH),
        .TRACE_MAX  (TRACE_MAX),
        .TRACE_DECAY(TRACE_DECAY)
      ) u_pre_trace (
        .clk    (clk),
        .reset_n(reset_n),
        .i_spike(pre_spike[gk]),
        .o_trace(w_pre_trace[gk])
      );
    end
  endgenerate

  stdp_trace #(
    .WIDTH      (WIDTH),
    .TRACE_MAX  (TRACE_MAX),
    .TRACE_DECAY(TRACE_DECAY)
  ) u_post_trace (
    .clk    (clk),
    .reset_n(reset_n),
    .i_spike(post_spike),
    .o_trace(w_post_trace)
  );

  // Next weight per channel from old traces and weights: a post spike with a
  // live pre trace potentiates; a lone pre spike with a live post trace
  // depresses. The post-spike test guards LTD, so the two never coincide.
  always_comb begin
    for (int k = 0; k < N_SYN; k++) begin
      w_weight_nx[k] = r_weight[k];
      if (learn_en) begin
        if (post_spike && (w_pre_trace[k] != '0)) begin
          w_weight_nx[k] = WIDTH'(sat_step(int'(r_weight[k]), LTP_STEP, W_MIN, W_MAX));
        end else if (pre_spike[k] && !post_spike && (w_post_trace != '0)) begin
          w_weight_nx[k] = WIDTH'(sat_step(int'(r_weight[k]), -LTD_STEP, W_MIN, W_MAX));
        end
      end
`ifdef STDP_WEIGHT_LOAD_EN
      if (wr_en && (32'(wr_addr) == k)) begin
        w_weight_nx[k] = WIDTH'(sat_step(int'(wr_data), 0, W_MIN, W_MAX));
      end
`endif
    end
  end

  // Weight registers take the computed next values every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_SYN; k++) begin
        r_weight[k] <= WIDTH'(W_INIT);
      end
    end else begin
      for (int k = 0; k < N_SYN; k++) begin
        r_weight[k] <= w_weight_nx[k];
      end
    end
  end

  // Summed drive of all spiking channels, each contributing twice its weight.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N_SYN; k++) begin
      if (pre_spike[k]) begin
        w_sum = w_sum + SW'({r_weight[k], 1'b0});
      end
    end
  end

  // Register the current, clamped to the largest positive signed value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_syn     <= '0;
      i_syn_sat <= 1'b0;
    end else begin
      i_syn     <= (w_sum > I_MAX) ? WIDTH'(I_MAX) : w_sum[WIDTH-1:0];
      i_syn_sat <= (w_sum > I_MAX);
    end
  end

  assign rd_weight = (32'(rd_addr) < N_SYN) ? r_weight[rd_addr] : '0;

endmodule

// File: tb/tb_stdp_synapse_array.sv
// Directed self-checking bench for stdp_synapse_array (default parameters).
// With STDP_WEIGHT_LOAD_EN defined, the weight write port is exercised too.
module tb_stdp_synapse_array;

  logic              clk;
  logic              reset_n;
  logic              learn_en;
  logic [3:0]        pre_spike;
  logic              post_spike;
  logic signed [7:0] i_syn;
  logic              i_syn_sat;
  logic [1:0]        rd_addr;
  logic [7:0]        rd_weight;
`ifdef STDP_WEIGHT_LOAD_EN
  logic              wr_en;
  logic [1:0]        wr_addr;
  logic [7:0]        wr_data;
`endif

  int tests_run;
  int tests_failed;

  stdp_synapse_array dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .learn_en  (learn_en),
    .pre_spike (pre_spike),
    .post_spike(post_spike),
    .i_syn     (i_syn),
    .i_syn_sat (i_syn_sat),
`ifdef STDP_WEIGHT_LOAD_EN
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`endif
    .rd_addr   (rd_addr),
    .rd_weight (rd_weight)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to one time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset low across a falling edge with all inputs idle.
  task automatic do_reset();
    learn_en   = 1'b0;
    pre_spike  = 4'b0000;
    post_spike = 1'b0;
    rd_addr    = 2'd0;
`ifdef STDP_WEIGHT_LOAD_EN
    wr_en   = 1'b0;
    wr_addr = 2'd0;
    wr_data = 8'd0;
`endif
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (i_syn !== 8'sd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_i_syn got %0d want 0", i_syn);
    end
    tests_run++;
    if (i_syn_sat !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_i_syn_sat got %b want 0", i_syn_sat);
    end
    for (int k = 0; k < 4; k++) begin
      rd_addr = 2'(k);
      #1;
      tests_run++;
      if (rd_weight !== 8'd16) begin
        tests_failed++;
        $display("[TB] FAIL reset_weight[%0d] got %0d want 16", k, rd_weight);
      end
    end
  endtask

  task automatic test_current();
    do_reset();
    pre_spike = 4'b0001;
    step();
    pre_spike = 4'b0000;
    tests_run++;
    if (i_syn !== 8'sd32 || i_syn_sat !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL current_single got %0d/%b want 32/0", i_syn, i_syn_sat);
    end
    step();
    tests_run++;
    if (i_syn !== 8'sd0) begin
      tests_failed++;
      $display("[TB] FAIL current_clear got %0d want 0", i_syn);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    pre_spike = 4'b0111;
    step();
    tests_run++;
    if (i_syn !== 8'sd96 || i_syn_sat !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL current_three got %0d/%b want 96/0", i_syn, i_syn_sat);
    end
    do_reset();
    pre_spike = 4'b1111;
    step();
    pre_spike = 4'b0000;
    tests_run++;
    if (i_syn !== 8'sd127 || i_syn_sat !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL current_sat got %0d/%b want 127/1", i_syn, i_syn_sat);
    end
    step();
    tests_run++;
    if (i_syn !== 8'sd0 || i_syn_sat !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL current_sat_clear got %0d/%b want 0/0", i_syn, i_syn_sat);
    end
  endtask

  task automatic test_ltp();
    int expected;
    do_reset();
    learn_en  = 1'b1;
    pre_spike = 4'b0001;
    step();
    pre_spike = 4'b0000;
    step();
    step();
    post_spike = 1'b1;
    step();
    rd_addr = 2'd0;
    #1;
    tests_run++;
    if (rd_weight !== 8'd24) begin
      tests_failed++;
      $display("[TB] FAIL ltp_first got %0d want 24", rd_weight);
    end
    expected = 24;
    for (int n = 0; n < 6; n++) begin
      step();
      expected = (expected + 8 > 64) ? 64 : expected + 8;
      tests_run++;
      if (rd_weight !== 8'(expected)) begin
        tests_failed++;
        $display("[TB] FAIL ltp_repeat%0d got %0d want %0d", n, rd_weight, expected);
      end
    end
    post_spike = 1'b0;
    rd_addr = 2'd1;
    #1;
    tests_run++;
    if (rd_weight !== 8'd16) begin
      tests_failed++;
      $display("[TB] FAIL ltp_other_channel got %0d want 16", rd_weight);
    end
  endtask

  task automatic test_ltd();
    int expected;
    do_reset();
    learn_en   = 1'b1;
    post_spike = 1'b1;
    step();
    post_spike = 1'b0;
    step();
    pre_spike = 4'b0010;
    rd_addr   = 2'd1;
    step();
    tests_run++;
    if (rd_weight !== 8'd12 || i_syn !== 8'sd32) begin
      tests_failed++;
      $display("[TB] FAIL ltd_first got w=%0d i=%0d want w=12 i=32", rd_weight, i_syn);
    end
    expected = 12;
    for (int n = 0; n < 3; n++) begin
      step();
      expected = (expected - 4 < 4) ? 4 : expected - 4;
      tests_run++;
      if (rd_weight !== 8'(expected)) begin
        tests_failed++;
        $display("[TB] FAIL ltd_repeat%0d got %0d want %0d", n, rd_weight, expected);
      end
    end
    pre_spike = 4'b0000;
  endtask

  task automatic test_window();
    do_reset();
    learn_en  = 1'b1;
    pre_spike = 4'b0100;
    step();
    pre_spike = 4'b0000;
    repeat (69) step();
    post_spike = 1'b1;
    step();
    post_spike = 1'b0;
    rd_addr = 2'd2;
    #1;
    tests_run++;
    if (rd_weight !== 8'd16) begin
      tests_failed++;
      $display("[TB] FAIL window_expired got %0d want 16", rd_weight);
    end
  endtask

  task automatic test_learn_disable();
    do_reset();
    learn_en  = 1'b0;
    pre_spike = 4'b0001;
    step();
    pre_spike = 4'b0000;
    step();
    step();
    post_spike = 1'b1;
    step();
    post_spike = 1'b0;
    rd_addr = 2'd0;
    #1;
    tests_run++;
    if (rd_weight !== 8'd16) begin
      tests_failed++;
      $display("[TB] FAIL learn_off_hold got %0d want 16", rd_weight);
    end
    learn_en   = 1'b1;
    post_spike = 1'b1;
    step();
    post_spike = 1'b0;
    tests_run++;
    if (rd_weight !== 8'd24) begin
      tests_failed++;
      $display("[TB] FAIL learn_on_trace_live got %0d want 24", rd_weight);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    learn_en  = 1'b1;
    pre_spike = 4'b0001;
    step();
    pre_spike  = 4'b0000;
    post_spike = 1'b1;
    repeat (3) step();
    post_spike = 1'b0;
    rd_addr = 2'd0;
    #1;
    tests_run++;
    if (rd_weight !== 8'd40) begin
      tests_failed++;
      $display("[TB] FAIL learned_40 got %0d want 40", rd_weight);
    end
    pre_spike = 4'b0001;
    step();
    pre_spike = 4'b0000;
    tests_run++;
    if (i_syn !== 8'sd80 || rd_weight !== 8'd36) begin
      tests_failed++;
      $display("[TB] FAIL pre_after_post got i=%0d w=%0d want i=80 w=36", i_syn, rd_weight);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (rd_weight !== 8'd16 || i_syn !== 8'sd0 || i_syn_sat !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset got w=%0d i=%0d s=%b want 16/0/0", rd_weight, i_syn, i_syn_sat);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

`ifdef STDP_WEIGHT_LOAD_EN
  task automatic test_weight_load();
    do_reset();
    rd_addr = 2'd3;
    wr_en   = 1'b1;
    wr_addr = 2'd3;
    wr_data = 8'd200;
    step();
    tests_run++;
    if (rd_weight !== 8'd64) begin
      tests_failed++;
      $display("[TB] FAIL load_clamp_high got %0d want 64", rd_weight);
    end
    wr_data = 8'd1;
    step();
    tests_run++;
    if (rd_weight !== 8'd4) begin
      tests_failed++;
      $display("[TB] FAIL load_clamp_low got %0d want 4", rd_weight);
    end
    wr_data = 8'd30;
    step();
    wr_en = 1'b0;
    tests_run++;
    if (rd_weight !== 8'd30) begin
      tests_failed++;
      $display("[TB] FAIL load_plain got %0d want 30", rd_weight);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    test_reset();
    test_current();
    test_saturation();
    test_ltp();
    test_ltd();
    test_window();
    test_learn_disable();
    test_async_reset();
`ifdef STDP_WEIGHT_LOAD_EN
    test_weight_load();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
